// File: rtl/serial_adder_pkg.sv
// serial_adder shared definitions.
// FSM encodings and sizing helper.
package serial_adder_defs;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int cnt_bits(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/serial_adder_fa_cell.sv
// serial_adder one-bit full adder.
// Purely combinational; the top shares it over all bits.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial A +/- B, one bit per cycle.
// start/done handshake, result registered until next completion.
module serial_adder
  import serial_adder_defs::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);

  localparam int CW = cnt_bits(WIDTH);

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] r_nx;
  logic [CW-1:0]    cnt;
  logic             c;
  logic             c_msb;
  logic             c_msb_nx;
  logic             s;
  logic             co;
  logic             last;

  fa_cell u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (c),
    .s    (s),
    .cout (co)
  );

  assign last = (cnt == CW'(WIDTH - 1));
  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

  always_comb begin
    r_nx            = r_sr >> 1;
    r_nx[WIDTH-1]   = s;
    c_msb_nx        = last ? c : c_msb;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: if (start) state_nx = ST_RUN;
      ST_RUN:  if (last)  state_nx = ST_DONE;
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr  <= '0;
      b_sr  <= '0;
      r_sr  <= '0;
      cnt   <= '0;
      c     <= 1'b0;
      c_msb <= 1'b0;
      Sum   <= '0;
      Cout  <= 1'b0;
      Ovf   <= 1'b0;
    end else if (state == ST_IDLE) begin
      if (start) begin
        a_sr <= A;
        b_sr <= sub ? ~B : B;
        c    <= sub;
        cnt  <= '0;
      end
    end else if (state == ST_RUN) begin
      a_sr  <= a_sr >> 1;
      b_sr  <= b_sr >> 1;
      r_sr  <= r_nx;
      c     <= co;
      c_msb <= c_msb_nx;
      cnt   <= cnt + CW'(1);
      if (last) begin
        Sum  <= r_nx;
        Cout <= co;
        Ovf  <= co ^ c_msb_nx;
      end
    end
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised bit-serial adder/subtractor. It computes `A ± B` over `WIDTH` clock cycles, one bit per cycle, using a single full-adder cell and a registered carry. It is the sequential, width-generic successor of the combinational one-bit full adder in the practicum gates series. It sits behind a simple start/done handshake and trades latency for area.

## Interface
- `WIDTH`, default 8: operand and result width in bits, ≥ 1.
- `clk`  in  1  single system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `sub`  in  1  0 = add, 1 = subtract (`A − B`); captured with `start`.
- `A`  in  WIDTH  operand A; captured with `start`.
- `B`  in  WIDTH  operand B; captured with `start`.
- `busy`  out  1  high while bits are being processed.
- `done`  out  1  one-cycle pulse when the result updates.
- `Sum`  out  WIDTH  registered result, held until the next completion.
- `Cout`  out  1  carry out of the MSB. In subtract mode it is the not-borrow flag.
- `Ovf`  out  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

## Operation
The block is a three-state FSM: IDLE → RUN → DONE → IDLE.

- **IDLE**
  - When `start`=1, load the operand shift registers: `a_sr`←`A` and `b_sr`←(`sub` ? ~`B` : `B`).
  - Set carry register `c`←`sub`, clear bit counter `cnt`, and go to RUN.
  - When `start`=0, stay in IDLE.
- **RUN**, each cycle:
  - s = `a_sr[0]` ^ `b_sr[0]` ^ `c`.
  - `c` ← majority(`a_sr[0]`, `b_sr[0]`, `c`).
  - Shift `a_sr` and `b_sr` right by one.
  - Shift s into the MSB of result shift register `r_sr`.
  - Before updating `c`, store it in `c_msb` when `cnt`=WIDTH−1.
  - `cnt`++. On the cycle with `cnt`=WIDTH−1, load the outputs: `Sum`←final `r_sr`, `Cout`←final `c`, `Ovf`←final `c` ^ `c_msb`. Then go to DONE.
- **DONE**: `done`=1 for exactly one cycle, then go to IDLE.
- `start` is ignored in RUN and DONE. There is no queuing.
- Operands and `sub` may change freely after the capture cycle.
- Arithmetic is modulo 2^WIDTH. `Sum` is exact in both unsigned and signed interpretation, apart from the flagged carry and overflow.
- `WIDTH`=1 is a legal degenerate case: RUN lasts one cycle and `Ovf` = carry-in XOR carry-out of bit 0.

## Timing
- `start` is sampled at rising edge k in IDLE.
- `busy`=1 during cycles k+1 … k+WIDTH. It is a Moore output: `busy` = (state==RUN).
- `Sum`, `Cout` and `Ovf` update at edge k+WIDTH. `done`=1 during cycle k+WIDTH+1 (state DONE).
- The earliest next accepted `start` is at edge k+WIDTH+2. Throughput is one operation per WIDTH+2 cycles.
- Outputs are stable between completions, so the previous result stays visible during RUN.
- Reset values:
  - Outputs: `busy`=0, `done`=0, `Sum`=0, `Cout`=0, `Ovf`=0.
  - Internal: state=IDLE, all shift registers, `c`, `c_msb` and `cnt` = 0.
- Reset mid-operation aborts immediately and asynchronously. No `done` pulse is issued and outputs return to 0. The first `start` after deassertion is accepted normally.
- `cnt` width is $clog2(WIDTH+1). The counter never wraps, because it is cleared on every load.

## Structure
- Shared header or package `serial_adder_defs`:
  - 2-bit state encodings `ST_IDLE`=2'd0, `ST_RUN`=2'd1, `ST_DONE`=2'd2.
  - `ST_DONE`=2'd2 is the last legal state. Illegal state 2'd3 recovers to IDLE.
- One natural sub-module: `fa_cell`, a purely combinational 1-bit full adder (a, b, cin → s, cout), instantiated once.
- The top level holds the FSM, the shift registers, the carry register and the output registers.
- All sequential logic uses a single always block style with `negedge rst_n` in the sensitivity list.

## Test plan
- **Basic add** (WIDTH=8, `sub`=0): `A`=100, `B`=27 → `Sum`=127, `Cout`=0, `Ovf`=0.
  - `busy` is high for exactly 8 cycles.
  - `done` pulses at start edge + 9.
- **Unsigned carry and signed overflow**: 8'hFF + 8'h01 → `Sum`=8'h00, `Cout`=1, `Ovf`=0. 8'h7F + 8'h01 → `Sum`=8'h80, `Cout`=0, `Ovf`=1.
- **Subtract**: `A`=5, `B`=7 → `Sum`=8'hFE, `Cout`=0, `Ovf`=0. 8'h80 − 8'h01 → `Sum`=8'h7F, `Cout`=1, `Ovf`=1.
- **Handshake**:
  - Pulse `start` again during RUN with different operands → it is ignored. The result matches the first operands and exactly one `done` is issued.
  - Previous `Sum` is held throughout RUN.
- **Reset mid-operation**: drive `rst_n` low at cycle 4 of RUN → all outputs are 0 immediately and `done` never pulses. A new `start` (3+4) then yields `Sum`=7.
- **Exhaustive check** (WIDTH=4 and WIDTH=1): all A × B × `sub` combinations checked against a behavioural model (`A`+`B` or `A`−`B`, plus carry and overflow) → zero mismatches.
